hazard_ctrl: RTL and testbench

//  Pipeline hazard controller for the RV32I 5-stage core. Drives the ForwardAE/ForwardBE selects of the
//  E-stage operand muxes, the load-use stall, the taken-branch flush, and a data-memory wait sequencer

---
 rtl/riscv_pkg.sv | 5 +
 rtl/hazard_ctrl_fwd_detect.sv | 14 +
 rtl/hazard_ctrl.sv | 99 +++++++++
 tb/tb_hazard_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types for the RV32I pipeline hazard logic.
package riscv_pkg;
    typedef enum logic [1:0] {FWD_RD = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10} fwd_sel_e;
    typedef enum logic [1:0] {HZ_RUN, HZ_MEM_WAIT, HZ_MEM_ERR} hz_state_e;
endpackage

// File: rtl/hazard_ctrl_fwd_detect.sv
// fwd_detect: picks the forwarding source for one E-stage operand; M beats W, x0 never forwarded.
module fwd_detect
    import riscv_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rdm,
    input  logic [4:0] rdw,
    input  logic       regwritem,
    input  logic       regwritew,
    output fwd_sel_e   sel
);
    assign sel = (regwritem && rdm != 5'd0 && rdm == rs) ? FWD_M :
                 (regwritew && rdw != 5'd0 && rdw == rs) ? FWD_W : FWD_RD;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, load-use stall, branch flush, dmem wait sequencer and perf counters.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    hz_state_e     state, state_n;
    logic [WW-1:0] wait_cnt, wait_n;
    logic          err_n;
    fwd_sel_e      fa, fb;
    logic          mem_stall, hold, load_use;

    fwd_detect u_fwd_a (.rs(Rs1E), .rdm(RdM), .rdw(RdW), .regwritem(RegWriteM), .regwritew(RegWriteW), .sel(fa));
    fwd_detect u_fwd_b (.rs(Rs2E), .rdm(RdM), .rdw(RdW), .regwritem(RegWriteM), .regwritew(RegWriteW), .sel(fb));

    // Freeze is combinational on the dmem handshake so the pipe never advances past a pending access.
    assign mem_stall = state != HZ_MEM_ERR && MemReqM && !MemReadyM;
    assign hold      = state == HZ_MEM_ERR || mem_stall;
    assign load_use  = ResultSrcE0 && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);

    assign ForwardAE = rst ? FWD_RD : fa;
    assign ForwardBE = rst ? FWD_RD : fb;
    assign StallF    = !rst && (hold || (!PCSrcE && load_use));
    assign StallD    = StallF;
    assign StallE    = !rst && hold;
    assign StallM    = StallE;
    assign FlushW    = StallE;
    assign FlushD    = !rst && !hold && PCSrcE;
    assign FlushE    = !rst && !hold && (PCSrcE || load_use);

    always_comb begin
        state_n = state;
        wait_n  = wait_cnt;
        err_n   = mem_err;
        case (state)
            HZ_RUN: if (mem_stall) begin
                state_n = HZ_MEM_WAIT;
                wait_n  = WW'(1);
            end
            HZ_MEM_WAIT: if (MemReadyM) begin
                state_n = HZ_RUN;
                wait_n  = '0;
            end else if (wait_cnt == WW'(MEM_TIMEOUT)) begin
                state_n = HZ_MEM_ERR;
                err_n   = 1'b1;
            end else begin
                wait_n = wait_cnt + WW'(1);
            end
            HZ_MEM_ERR: state_n = HZ_MEM_ERR;
            default: state_n = HZ_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HZ_RUN;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_n;
            wait_cnt  <= wait_n;
            mem_err   <= err_n;
            stall_cnt <= stall_cnt + CNT_W'(StallF);
            flush_cnt <= flush_cnt + CNT_W'(FlushD);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table vectors, directed multi-cycle sequences and a randomized run against a behavioural model.
module tb_hazard_ctrl;
    localparam int T = 4;
    logic        clk = 1'b0, rst = 1'b1;
    logic [4:0]  Rs1D = 0, Rs2D = 0, Rs1E = 0, Rs2E = 0, RdE = 0, RdM = 0, RdW = 0;
    logic        RegWriteM = 0, RegWriteW = 0, ResultSrcE0 = 0, PCSrcE = 0, MemReqM = 0, MemReadyM = 1;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
    logic [31:0] stall_cnt, flush_cnt;
    int checks = 0, errors = 0;

    hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE),
        .FlushW(FlushW), .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM} = '0;
        MemReadyM = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Spec-level forwarding rule.
    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    typedef struct {
        logic [4:0] rs1e, rs2e, rdm, rdw;
        logic       rwm, rww;
        logic [4:0] rs1d, rs2d, rde;
        logic       ld, br;
        logic [1:0] ea, eb;
        logic [3:0] ectl;
    } vec_t;
    vec_t tbl[10];

    int streak, exp_scnt, exp_fcnt;
    logic merr;

    initial begin
        // ectl = {StallF, StallD, FlushD, FlushE}
        tbl[0] = '{5, 0, 5, 5, 1, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 4'b0000};
        tbl[1] = '{5, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 4'b0000};
        tbl[2] = '{3, 3, 3, 3, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b01, 4'b0000};
        tbl[3] = '{4, 9, 9, 4, 1, 1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 4'b0000};
        tbl[4] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000};
        tbl[5] = '{1, 0, 2, 0, 1, 0, 7, 0, 7, 1, 0, 2'b00, 2'b00, 4'b1101};
        tbl[6] = '{0, 0, 0, 0, 0, 0, 1, 7, 7, 1, 1, 2'b00, 2'b00, 4'b0011};
        tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'b0000};
        tbl[8] = '{0, 0, 0, 0, 0, 0, 7, 0, 7, 0, 0, 2'b00, 2'b00, 4'b0000};
        tbl[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 4'b0011};

        // Reset with every trigger active: all outputs must be 0.
        #1;
        Rs1E = 5; RdM = 5; RegWriteM = 1; PCSrcE = 1; MemReqM = 1; MemReadyM = 0;
        ResultSrcE0 = 1; RdE = 7; Rs1D = 7;
        tick();
        chk("rst_fwd", {30'd0, ForwardAE}, 0);
        chk("rst_ctl", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err}, 0);
        chk("rst_cnt", stall_cnt | flush_cnt, 0);
        clear_inputs();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            Rs1E = tbl[i].rs1e; Rs2E = tbl[i].rs2e; RdM = tbl[i].rdm; RdW = tbl[i].rdw;
            RegWriteM = tbl[i].rwm; RegWriteW = tbl[i].rww; Rs1D = tbl[i].rs1d; Rs2D = tbl[i].rs2d;
            RdE = tbl[i].rde; ResultSrcE0 = tbl[i].ld; PCSrcE = tbl[i].br;
            #2;
            chk($sformatf("tbl%0d_fa", i), {30'd0, ForwardAE}, {30'd0, tbl[i].ea});
            chk($sformatf("tbl%0d_fb", i), {30'd0, ForwardBE}, {30'd0, tbl[i].eb});
            chk($sformatf("tbl%0d_ctl", i), {28'd0, StallF, StallD, FlushD, FlushE}, {28'd0, tbl[i].ectl});
            chk($sformatf("tbl%0d_hold", i), {29'd0, StallE, StallM, FlushW}, 0);
        end
        clear_inputs();
        do_reset();

        // Load-use for exactly one cycle.
        ResultSrcE0 = 1; RdE = 7; Rs1D = 7;
        #2 chk("lu_ctl", {StallF, StallD, FlushD, FlushE}, 4'b1101);
        tick();
        chk("lu_scnt", stall_cnt, 1);
        clear_inputs();
        #2 chk("lu_release", {StallF, StallD, FlushE}, 0);
        tick();
        chk("lu_scnt_hold", stall_cnt, 1);

        // Load-use overridden by a taken branch.
        ResultSrcE0 = 1; RdE = 7; Rs1D = 7; PCSrcE = 1;
        #2 chk("br_ctl", {StallF, StallD, FlushD, FlushE}, 4'b0011);
        tick();
        chk("br_fcnt", flush_cnt, 1);
        chk("br_scnt", stall_cnt, 1);
        clear_inputs();

        // Three dmem wait cycles, branch ignored while frozen.
        MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk($sformatf("mw%0d_stall", i), {StallF, StallD, StallE, StallM, FlushW}, 5'b11111);
            chk($sformatf("mw%0d_flush", i), {FlushD, FlushE}, 0);
            tick();
        end
        MemReadyM = 1;
        #2;
        chk("mw_release", {StallF, StallD, StallE, StallM, FlushW}, 0);
        chk("mw_release_br", {FlushD, FlushE}, 2'b11);
        tick();
        chk("mw_scnt", stall_cnt, 4);
        chk("mw_fcnt", flush_cnt, 2);
        chk("mw_err", mem_err, 0);
        clear_inputs();
        do_reset();

        // Timeout: five consecutive not-ready cycles (RUN entry plus T waits) latch mem_err.
        MemReqM = 1; MemReadyM = 0;
        for (int i = 1; i <= T + 1; i++) begin
            tick();
            chk($sformatf("to%0d_err", i), mem_err, i == T + 1);
        end
        MemReqM = 0; MemReadyM = 1; PCSrcE = 1;
        #2;
        chk("err_hold", {StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE}, 7'b1111100);
        tick();
        chk("err_sticky", mem_err, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_inputs();
        #2;
        chk("err_rst", {StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE, mem_err}, 0);
        chk("err_rst_cnt", stall_cnt | flush_cnt, 0);

        // Randomized run against the behavioural model.
        do_reset();
        streak = 0; merr = 0; exp_scnt = 0; exp_fcnt = 0;
        for (int n = 0; n < 600; n++) begin
            logic es, ef, eh, efe, lu, ms;
            rst = ($urandom_range(0, 79) == 0);
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE = 5'($urandom_range(0, 3)); RdM = 5'($urandom_range(0, 3)); RdW = 5'($urandom_range(0, 3));
            RegWriteM = 1'($urandom); RegWriteW = 1'($urandom); ResultSrcE0 = 1'($urandom);
            PCSrcE = ($urandom_range(0, 3) == 0); MemReqM = 1'($urandom);
            MemReadyM = ($urandom_range(0, 3) != 0);
            #2;
            lu = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
            ms = MemReqM && !MemReadyM;
            {es, eh, ef, efe} = '0;
            if (rst) ;
            else if (merr || ms) begin es = 1; eh = 1; end
            else if (PCSrcE) begin ef = 1; efe = 1; end
            else if (lu) begin es = 1; efe = 1; end
            chk("rnd_fa", {30'd0, ForwardAE}, rst ? 0 : {30'd0, fwd(Rs1E)});
            chk("rnd_fb", {30'd0, ForwardBE}, rst ? 0 : {30'd0, fwd(Rs2E)});
            chk("rnd_ctl", {StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE},
                {es, es, eh, eh, eh, ef, efe});
            @(posedge clk);
            if (rst) begin
                streak = 0; merr = 0; exp_scnt = 0; exp_fcnt = 0;
            end else begin
                exp_scnt += int'(es);
                exp_fcnt += int'(ef);
                if (!merr) begin
                    if (MemReadyM) streak = 0;
                    else if (streak > 0 || MemReqM) streak++;
                    if (streak > T) merr = 1;
                end
            end
            #1;
            chk("rnd_err", mem_err, merr);
            chk("rnd_scnt", stall_cnt, exp_scnt);
            chk("rnd_fcnt", flush_cnt, exp_fcnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
